// File: rtl/data_memory_unit_if.sv
// rtl/data_memory_unit_if.sv - load/store bus between the core and the data memory unit
interface data_memory_unit_if;
    logic        Mem_Write;
    logic        Mem_Read;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] Write_Data;
    logic [31:0] Read_Data;
    logic        Misaligned;

    modport master (
        output Mem_Write, Mem_Read, Funct3, Addr, Write_Data,
        input  Read_Data, Misaligned
    );

    modport slave (
        input  Mem_Write, Mem_Read, Funct3, Addr, Write_Data,
        output Read_Data, Misaligned
    );
endinterface

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - byte-addressable data RAM plus LED/switch/cycle-counter MMIO page
module data_memory_unit #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_unit_if.slave   bus,
    input  logic [15:0]         Switches,
    output logic [15:0]         LEDs
);
    localparam int          BYTE_AW   = $clog2(4 * DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    // No reset on the array so it maps onto block/distributed RAM.
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [15:0] leds_q, leds_d;
    logic [31:0] cnt_q;
    logic [15:0] sw_meta_q, sw_sync_q;

    logic               access, is_half, is_word, store_ok, misaligned, store_en;
    logic               hit_ram, hit_led, hit_sw, hit_cnt, mapped;
    logic [BYTE_AW-3:0] word_idx;
    logic [31:0]        raw_word, lane_word, load_ext;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_al;

    always_comb begin
        access     = bus.Mem_Read | bus.Mem_Write;
        is_half    = (bus.Funct3[1:0] == 2'b01);
        is_word    = (bus.Funct3 == 3'b010);
        store_ok   = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010);
        misaligned = access && ((is_half && bus.Addr[0]) || (is_word && (bus.Addr[1:0] != 2'b00)));
        store_en   = bus.Mem_Write && !misaligned && store_ok;
    end

    // MMIO registers decode on the word address; sub-word offsets pick lanes.
    always_comb begin
        hit_ram  = (bus.Addr < RAM_BYTES);
        hit_led  = (bus.Addr[31:2] == MMIO_BASE[31:2]);
        hit_sw   = (bus.Addr[31:2] == MMIO_BASE[31:2] + 30'd1);
        hit_cnt  = (bus.Addr[31:2] == MMIO_BASE[31:2] + 30'd2);
        mapped   = hit_ram || hit_led || hit_sw || hit_cnt;
        word_idx = bus.Addr[BYTE_AW-1:2];
    end

    always_comb begin
        raw_word = 32'h0;
        if (hit_ram)      raw_word = mem_q[word_idx];
        else if (hit_led) raw_word = {16'h0, leds_q};
        else if (hit_sw)  raw_word = {16'h0, sw_sync_q};
        else if (hit_cnt) raw_word = cnt_q;
    end

    always_comb begin
        lane_word = raw_word >> {bus.Addr[1:0], 3'b000};
        case (bus.Funct3)
            3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b010:  load_ext = raw_word;
            3'b100:  load_ext = {24'h0, lane_word[7:0]};
            3'b101:  load_ext = {16'h0, lane_word[15:0]};
            default: load_ext = 32'h0;
        endcase
    end

    assign bus.Read_Data  = (bus.Mem_Read && !misaligned && mapped) ? load_ext : 32'h0;
    assign bus.Misaligned = misaligned;
    assign LEDs           = leds_q;

    always_comb begin
        case (bus.Funct3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << bus.Addr[1:0];
                wdata_al = {4{bus.Write_Data[7:0]}};
            end
            2'b01: begin
                byte_en  = bus.Addr[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{bus.Write_Data[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wdata_al = bus.Write_Data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && store_en && hit_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

    always_comb begin
        leds_d = leds_q;
        if (store_en && hit_led) begin
            if (byte_en[0]) leds_d[7:0]  = wdata_al[7:0];
            if (byte_en[1]) leds_d[15:8] = wdata_al[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q    <= 16'h0;
            cnt_q     <= 32'h0;
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
        end else begin
            leds_q    <= leds_d;
            cnt_q     <= cnt_q + 32'd1;
            sw_meta_q <= Switches;
            sw_sync_q <= sw_meta_q;
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - directed bench with a byte-level reference model of the memory unit
module tb_data_memory_unit;
    localparam int          DEPTH = 256;
    localparam logic [31:0] MB    = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Switches = 16'h0;
    logic [15:0] LEDs;

    data_memory_unit_if bus();

    data_memory_unit #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .Switches (Switches),
        .LEDs     (LEDs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_mem [int];
    logic [15:0] m_leds;
    logic [31:0] m_cnt;
    logic [15:0] m_sw [2];

    function automatic logic model_mis();
        int f;
        f = bus.Funct3;
        return (bus.Mem_Read || bus.Mem_Write) &&
               (((f == 1 || f == 5) && bus.Addr % 2 != 0) || (f == 2 && bus.Addr % 4 != 0));
    endfunction

    function automatic void model_read(output logic ok, output logic [31:0] d);
        logic [31:0] w, base, v;
        int f, n;
        ok = 1'b1; d = 32'h0; w = 32'h0;
        f = bus.Funct3;
        if (!bus.Mem_Read || model_mis()) return;
        if (!(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return;
        base = bus.Addr & ~32'd3;
        if (bus.Addr < 4 * DEPTH) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_mem.exists(int'(base) + k)) ok = 1'b0;
                else w[8*k +: 8] = m_mem[int'(base) + k];
            end
        end else if (base == MB)     w = {16'h0, m_leds};
        else if (base == MB + 4)     w = {16'h0, m_sw[1]};
        else if (base == MB + 8)     w = m_cnt;
        else return;
        n = 1 << (f % 4);
        v = w >> (8 * (bus.Addr % 4));
        if (n == 1) begin
            d = {24'h0, v[7:0]};
            if (f < 4 && v[7]) d = d | 32'hFFFF_FF00;
        end else if (n == 2) begin
            d = {16'h0, v[15:0]};
            if (f < 4 && v[15]) d = d | 32'hFFFF_0000;
        end else d = w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_leds = 16'h0; m_cnt = 32'h0; m_sw[0] = 16'h0; m_sw[1] = 16'h0;
        end else begin
            if (bus.Mem_Write && !model_mis() && bus.Funct3 <= 3'd2) begin
                for (int k = 0; k < (1 << bus.Funct3); k++) begin
                    int a;
                    a = int'(bus.Addr) + k;
                    if (bus.Addr < 4 * DEPTH) m_mem[a] = bus.Write_Data[8*k +: 8];
                    else if ((bus.Addr & ~32'd3) == MB && a % 4 < 2) begin
                        if (a % 4 == 0) m_leds[7:0]  = bus.Write_Data[8*k +: 8];
                        else            m_leds[15:8] = bus.Write_Data[8*k +: 8];
                    end
                end
            end
            m_cnt   = m_cnt + 1;
            m_sw[1] = m_sw[0];
            m_sw[0] = Switches;
        end
    end

    always @(negedge clk) begin
        logic ok;
        logic [31:0] d;
        checks++;
        if (bus.Misaligned !== model_mis()) begin
            errors++;
            $display("FAIL misaligned t=%0t got %b want %b", $time, bus.Misaligned, model_mis());
        end
        checks++;
        if (LEDs !== m_leds) begin
            errors++;
            $display("FAIL leds t=%0t got %h want %h", $time, LEDs, m_leds);
        end
        model_read(ok, d);
        if (ok) begin
            checks++;
            if (bus.Read_Data !== d) begin
                errors++;
                $display("FAIL read_data t=%0t addr %h f3 %0d got %h want %h",
                         $time, bus.Addr, bus.Funct3, bus.Read_Data, d);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.Mem_Read = rd; bus.Mem_Write = wr; bus.Funct3 = f3;
        bus.Addr = a; bus.Write_Data = wd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        drive(0, 0, 3'b010, 32'h0, 32'h0);
        step(); step();
        chk("reset_leds", {16'h0, LEDs}, 32'h0);
        rst = 1'b0;
        drive(1, 0, 3'b010, MB + 8, 0);
        for (int i = 0; i < 10; i++) step();
        #1 chk("counter_10", bus.Read_Data, 32'd10);

        drive(0, 1, 3'b010, 32'h10, 32'hDEADBEEF); step();
        drive(1, 0, 3'b010, 32'h10, 0); chk("lw_10", bus.Read_Data, 32'hDEADBEEF); step();
        drive(1, 0, 3'b000, 32'h10, 0); chk("lb_10", bus.Read_Data, 32'hFFFFFFEF); step();
        drive(1, 0, 3'b100, 32'h10, 0); chk("lbu_10", bus.Read_Data, 32'h000000EF); step();
        drive(1, 0, 3'b001, 32'h10, 0); chk("lh_10", bus.Read_Data, 32'hFFFFBEEF); step();
        drive(1, 0, 3'b101, 32'h12, 0); chk("lhu_12", bus.Read_Data, 32'h0000DEAD); step();
        drive(1, 0, 3'b000, 32'h13, 0); chk("lb_13", bus.Read_Data, 32'hFFFFFFDE); step();

        drive(0, 1, 3'b010, 32'h20, 32'h11223344); step();
        drive(0, 1, 3'b000, 32'h21, 32'h000000AA); step();
        drive(0, 1, 3'b001, 32'h22, 32'h00005566); step();
        drive(1, 0, 3'b010, 32'h20, 0); chk("merge_20", bus.Read_Data, 32'h5566AA44); step();

        drive(1, 0, 3'b010, 32'h22, 0);
        chk("mis_lw", {31'h0, bus.Misaligned}, 32'h1);
        chk("mis_lw_data", bus.Read_Data, 32'h0); step();
        drive(0, 1, 3'b001, 32'h23, 32'h0000FFFF);
        chk("mis_sh", {31'h0, bus.Misaligned}, 32'h1); step();
        drive(0, 1, 3'b011, 32'h20, 32'h0BADF00D); step();
        drive(1, 0, 3'b011, 32'h20, 0); chk("bad_f3_load", bus.Read_Data, 32'h0); step();
        drive(1, 0, 3'b010, 32'h20, 0); chk("unchanged_20", bus.Read_Data, 32'h5566AA44); step();

        drive(1, 1, 3'b010, 32'h20, 32'h12345678);
        chk("rw_pre_edge", bus.Read_Data, 32'h5566AA44); step();
        #1 chk("rw_post_edge", bus.Read_Data, 32'h12345678);

        drive(0, 1, 3'b010, MB, 32'h0000A5A5); step();
        chk("leds_a5a5", {16'h0, LEDs}, 32'h0000A5A5);
        drive(0, 1, 3'b000, MB + 1, 32'h0000003C); step();
        drive(0, 1, 3'b001, MB + 2, 32'h0000FFFF); step();
        drive(0, 1, 3'b010, MB + 8, 32'h0); step();
        chk("leds_sb", {16'h0, LEDs}, 32'h00003CA5);
        drive(1, 0, 3'b000, MB + 1, 0); chk("lb_led_hi", bus.Read_Data, 32'h0000003C);
        drive(1, 0, 3'b010, 32'h0000_2000, 0); chk("unmapped", bus.Read_Data, 32'h0);

        Switches = 16'h1234;
        drive(1, 0, 3'b010, MB + 4, 0); step();
        chk("sw_1edge", bus.Read_Data, 32'h0); step();
        chk("sw_2edge", bus.Read_Data, 32'h00001234);
        drive(1, 0, 3'b001, MB + 4, 0); chk("lh_sw", bus.Read_Data, 32'h00001234); step();

        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 3'b010, 32'h40 + 4 * i, 32'h80F1_7F02 ^ (32'h1111_1111 * i)); step();
        end
        for (int i = 0; i < 6; i++) begin
            for (int f = 0; f < 8; f++) begin
                for (int o = 0; o < 4; o++) begin
                    drive(1, 0, 3'(f), 32'h40 + 4 * i + o, 0); step();
                end
            end
        end

        drive(0, 1, 3'b010, 32'h30, 32'h01020304); step();
        drive(0, 1, 3'b010, MB, 32'h0000FFFF); step();
        drive(0, 1, 3'b010, 32'h30, 32'hFFFFFFFF);
        rst = 1'b1;
        #1 chk("rst_leds_async", {16'h0, LEDs}, 32'h0);
        step(); step();
        drive(1, 0, 3'b010, MB + 8, 0); chk("rst_cnt", bus.Read_Data, 32'h0);
        rst = 1'b0;
        drive(1, 0, 3'b010, 32'h30, 0); chk("no_store_in_rst", bus.Read_Data, 32'h01020304);
        drive(1, 0, 3'b010, MB + 8, 0); step();
        chk("cnt_resume", bus.Read_Data, 32'd1);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit RAM words (power of two, max 1024).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h0000_1000, base address of the I/O register page.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 Mem_Write  input  1  store enable.
REQ-006 Mem_Read  input  1  load enable.
REQ-007 Funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Addr  input  32  byte address from ALU result.
REQ-009 Write_Data  input  32  store data, taken from rs2 with LSB alignment.
REQ-010 Switches  input  16  asynchronous board switch inputs.
REQ-011 Read_Data  output  32  extended load data; drives the load input of the writeback result select.
REQ-012 LEDs  output  16  LED register contents.
REQ-013 Misaligned  output  1  current access is misaligned.

Function
REQ-014 Address decode SHALL be as follows: RAM when Addr < 4*DEPTH_WORDS, word index Addr[log2(4*DEPTH_WORDS)-1:2]; LED register at MMIO_BASE+0 (RW, bits 15:0); switch register at MMIO_BASE+4 (RO); cycle counter at MMIO_BASE+8 (RO); all other addresses unmapped.
REQ-015 Misaligned SHALL be combinational: 1 when (Mem_Read|Mem_Write) and (H/HU with Addr[0]=1, or W with Addr[1:0]!=0); else 0.
REQ-016 Read path SHALL be combinational, with zero-cycle latency, to support single-cycle execution.
REQ-017 Read_Data SHALL be 0 when Mem_Read=0, when Misaligned=1, for an unsupported Funct3 (011, 110, 111), or for an unmapped address.
REQ-018 Loads SHALL select byte lane Addr[1:0] or halfword lane Addr[1]; B/H SHALL sign-extend and BU/HU SHALL zero-extend to 32 bits.
REQ-019 MMIO reads SHALL return zero-extended 16-bit LED or switch values and the full 32-bit counter; sub-word MMIO loads SHALL apply the same lane and extension rules.
REQ-020 Stores SHALL commit on the rising clk edge when Mem_Write=1, Misaligned=0, Funct3 is in {000, 001, 010} and rst=0.
REQ-021 Store byte enables SHALL be: SB writes lane Addr[1:0] with Write_Data[7:0]; SH writes lanes Addr[1]*2..+1 with Write_Data[15:0]; SW writes all lanes. Other bytes SHALL be unchanged.
REQ-022 LED register SHALL update only through a store to MMIO_BASE+0; SB/SH SHALL update only the addressed lanes within bits 15:0. Writes to switch, counter and unmapped addresses SHALL be ignored.
REQ-023 Switches SHALL pass through a 2-flop synchronizer; a change SHALL become readable after exactly 2 rising edges.
REQ-024 Cycle counter SHALL increment by 1 every clock edge while rst=0 and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025 With Mem_Read=1 and Mem_Write=1 to the same location, Read_Data SHALL show the pre-edge contents; new data SHALL be visible after the edge.
REQ-026 Misaligned or unsupported accesses SHALL leave all state unchanged; no trap is raised here.

Reset
REQ-027 While rst=1: LEDs=0, counter=0, synchronizer flops=0, and no RAM or LED write SHALL occur.
REQ-028 RAM contents SHALL NOT be cleared by reset (block-RAM inference); RAM is undefined until first written.
REQ-029 Deasserting rst mid-operation SHALL resume counting from 0 on the first edge with rst=0; there SHALL be no partial store.

Verification
REQ-030 SW 0xDEADBEEF @0x10, then LW/LB/LBU/LH/LHU @0x10..0x13 -> 0xDEADBEEF, 0xFFFFFFEF, 0x000000EF, 0xFFFFBEEF (@0x10), 0x0000DEAD (@0x12), 0xFFFFFFDE (LB @0x13).
REQ-031 SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0x5566 @0x22 -> LW @0x20 = 0x5566AA44.
REQ-032 LW @0x22 and SH @0x23 -> Misaligned=1, Read_Data=0, RAM @0x20 unchanged.
REQ-033 SW 0x0000A5A5 to MMIO_BASE -> LEDs=0xA5A5 next edge; Switches=0x1234 -> LW MMIO_BASE+4 = 0 after 1 edge, 0x00001234 after 2 edges.
REQ-034 Release rst, run 10 edges -> LW MMIO_BASE+8 = 10; assert rst asynchronously mid-cycle -> counter and LEDs = 0 immediately; store attempted during rst -> RAM unchanged.
